// File: rtl/lcd1602_face_update_unit.sv
// rtl/lcd1602_face_update_unit.sv - pet-state change detector and 2x2 custom-face painter for a 16x2 LCD
`timescale 1ns/1ps
module lcd1602_face_update_unit #(
  parameter int MAX_VALUE = 5,
  parameter int NUM_FACES = 9,
  localparam int SW = $clog2(MAX_VALUE),
  localparam int FW = $clog2(NUM_FACES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_16ms,
  input  logic [FW-1:0] face,
  input  logic [SW-1:0] hunger,
  input  logic [SW-1:0] joy,
  input  logic [SW-1:0] energy,
  input  logic          update_ack,
  output logic          new_update,
  input  logic [FW-1:0] num_cust_char,
  input  logic          start_painting,
  output logic          lcd_available,
  output logic          rs,
  output logic          rw,
  output logic [7:0]    data
);

  typedef enum logic [1:0] {IDLE, LOAD, PLACE} state_t;

  state_t        state, state_n;
  logic [5:0]    cnt, cnt_n;
  logic [FW-1:0] face_q, face_n;
  logic          rs_n, avail_n;
  logic [7:0]    data_n;
  logic          clk_16ms_q;
  logic          tick;

  logic [FW-1:0] snap_face;
  logic [SW-1:0] snap_hunger, snap_joy, snap_energy;
  logic          differs;

  assign rw   = 1'b0;
  assign tick = clk_16ms & ~clk_16ms_q;

  // Eye row of the top-left glyph; the outline pixel sits in bit 4.
  function automatic logic [4:0] eye_row(input logic [FW-1:0] f);
    case (32'(f))
      0:       eye_row = 5'b11011;
      1:       eye_row = 5'b10100;
      2:       eye_row = 5'b11110;
      3:       eye_row = 5'b10010;
      4:       eye_row = 5'b10110;
      5:       eye_row = 5'b11010;
      6:       eye_row = 5'b10101;
      7:       eye_row = 5'b10011;
      8:       eye_row = 5'b10001;
      default: eye_row = 5'b10000;
    endcase
  endfunction

  // Mouth row of the bottom-left glyph.
  function automatic logic [4:0] mouth_row(input logic [FW-1:0] f);
    case (32'(f))
      0:       mouth_row = 5'b10011;
      1:       mouth_row = 5'b10001;
      2:       mouth_row = 5'b10111;
      3:       mouth_row = 5'b10010;
      4:       mouth_row = 5'b10100;
      5:       mouth_row = 5'b11011;
      6:       mouth_row = 5'b10110;
      7:       mouth_row = 5'b10001;
      8:       mouth_row = 5'b10101;
      default: mouth_row = 5'b10000;
    endcase
  endfunction

  function automatic logic [4:0] mirror(input logic [4:0] v);
    for (int i = 0; i < 5; i++) mirror[i] = v[4-i];
  endfunction

  // Face ROM: idx = glyph*8 + row; right-hand glyphs are mirrors of the left ones.
  function automatic logic [4:0] face_row(input logic [FW-1:0] f, input logic [4:0] idx);
    logic [4:0] left;
    if (!idx[4]) begin
      case (idx[2:0])
        3'd0:    left = 5'b00011;
        3'd1:    left = 5'b00100;
        3'd2:    left = 5'b01000;
        3'd3:    left = eye_row(f);
        3'd4:    left = eye_row(f);
        default: left = 5'b10000;
      endcase
    end else begin
      case (idx[2:0])
        3'd2:    left = mouth_row(f);
        3'd4:    left = 5'b01000;
        3'd5:    left = 5'b00100;
        3'd6:    left = 5'b00011;
        3'd7:    left = 5'b00000;
        default: left = 5'b10000;
      endcase
    end
    face_row = idx[3] ? mirror(left) : left;
  endfunction

  assign differs = (face != snap_face) || (hunger != snap_hunger) ||
                   (joy != snap_joy) || (energy != snap_energy);

  // Snapshot of the last acknowledged state and the sticky change flag; ack beats a same-cycle change.
  always_ff @(posedge clk) begin
    if (!reset) begin
      snap_face   <= '0;
      snap_hunger <= SW'(MAX_VALUE);
      snap_joy    <= SW'(MAX_VALUE);
      snap_energy <= SW'(MAX_VALUE);
      new_update  <= 1'b0;
    end else if (update_ack) begin
      snap_face   <= face;
      snap_hunger <= hunger;
      snap_joy    <= joy;
      snap_energy <= energy;
      new_update  <= 1'b0;
    end else if (differs) begin
      new_update  <= 1'b1;
    end
  end

  // Painter state register, LCD bus outputs and slow-strobe edge history.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      face_q        <= '0;
      rs            <= 1'b0;
      data          <= 8'h00;
      lcd_available <= 1'b1;
      clk_16ms_q    <= clk_16ms;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      face_q        <= face_n;
      rs            <= rs_n;
      data          <= data_n;
      lcd_available <= avail_n;
      clk_16ms_q    <= clk_16ms;
    end
  end

  // Next write on each strobe tick: CGRAM address, 32 glyph rows, 6 placement writes, then release.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    face_n  = face_q;
    rs_n    = rs;
    data_n  = data;
    avail_n = lcd_available;
    if (tick) begin
      case (state)
        IDLE: begin
          if (start_painting) begin
            face_n  = (32'(num_cust_char) >= NUM_FACES) ? '0 : num_cust_char;
            rs_n    = 1'b0;
            data_n  = 8'h40;
            avail_n = 1'b0;
            cnt_n   = '0;
            state_n = LOAD;
          end
        end
        LOAD: begin
          rs_n   = 1'b1;
          data_n = {3'b000, face_row(face_q, cnt[4:0])};
          if (cnt == 6'd31) begin
            cnt_n   = '0;
            state_n = PLACE;
          end else begin
            cnt_n = cnt + 6'd1;
          end
        end
        PLACE: begin
          cnt_n = cnt + 6'd1;
          case (cnt)
            6'd0:    begin rs_n = 1'b0; data_n = 8'h81; end
            6'd1:    begin rs_n = 1'b1; data_n = 8'h00; end
            6'd2:    begin rs_n = 1'b1; data_n = 8'h01; end
            6'd3:    begin rs_n = 1'b0; data_n = 8'hC1; end
            6'd4:    begin rs_n = 1'b1; data_n = 8'h02; end
            6'd5:    begin rs_n = 1'b1; data_n = 8'h03; end
            default: begin
              rs_n    = 1'b0;
              data_n  = 8'h00;
              avail_n = 1'b1;
              cnt_n   = '0;
              state_n = IDLE;
            end
          endcase
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd1602_face_update_unit.sv
// tb/tb_lcd1602_face_update_unit.sv - scoreboard bench for the LCD face update unit
`timescale 1ns/1ps
module tb_lcd1602_face_update_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clk_16ms = 1'b0;
  logic [3:0] face = 4'd0;
  logic [2:0] hunger = 3'd5, joy = 3'd5, energy = 3'd5;
  logic       update_ack = 1'b0;
  logic       new_update;
  logic [3:0] num_cust_char = 4'd0;
  logic       start_painting = 1'b0;
  logic       lcd_available, rs, rw;
  logic [7:0] data;

  lcd1602_face_update_unit #(.MAX_VALUE(5), .NUM_FACES(9)) dut (
    .clk(clk), .reset(reset), .clk_16ms(clk_16ms), .face(face),
    .hunger(hunger), .joy(joy), .energy(energy), .update_ack(update_ack),
    .new_update(new_update), .num_cust_char(num_cust_char),
    .start_painting(start_painting), .lcd_available(lcd_available),
    .rs(rs), .rw(rw), .data(data)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic       at_tick;
    logic       avail;
    logic       rs;
    logic [7:0] data;
  } pexp_t;

  pexp_t pq[$];
  logic  cq[$];
  int    pidx = 0;
  int    cidx = 0;

  // Hand-drawn glyph rows (glyph 0..3, row 0..7) of face 4 and face 0.
  logic [4:0] face4_rows [32] = '{
    5'b00011, 5'b00100, 5'b01000, 5'b10110, 5'b10110, 5'b10000, 5'b10000, 5'b10000,
    5'b11000, 5'b00100, 5'b00010, 5'b01101, 5'b01101, 5'b00001, 5'b00001, 5'b00001,
    5'b10000, 5'b10000, 5'b10100, 5'b10000, 5'b01000, 5'b00100, 5'b00011, 5'b00000,
    5'b00001, 5'b00001, 5'b00101, 5'b00001, 5'b00010, 5'b00100, 5'b11000, 5'b00000};
  logic [4:0] face0_rows [32] = '{
    5'b00011, 5'b00100, 5'b01000, 5'b11011, 5'b11011, 5'b10000, 5'b10000, 5'b10000,
    5'b11000, 5'b00100, 5'b00010, 5'b11011, 5'b11011, 5'b00001, 5'b00001, 5'b00001,
    5'b10000, 5'b10000, 5'b10011, 5'b10000, 5'b01000, 5'b00100, 5'b00011, 5'b00000,
    5'b00001, 5'b00001, 5'b11001, 5'b00001, 5'b00010, 5'b00100, 5'b11000, 5'b00000};
  logic [7:0] place_data [6] = '{8'h81, 8'h00, 8'h01, 8'hC1, 8'h02, 8'h03};
  logic       place_rs   [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  // Slow LCD strobe: 32 clk period, 16 low then 16 high.
  logic slow_en = 1'b0;
  int   slow_cnt = 0;
  always @(negedge clk) begin
    if (slow_en) begin
      slow_cnt = (slow_cnt + 1) % 32;
      clk_16ms = (slow_cnt >= 16);
    end
  end

  // Monitor: flag checks every clk, LCD writes on the clk after each strobe tick.
  logic prev16 = 1'b0;
  always @(posedge clk) begin : monitor
    logic  tk;
    logic  ce;
    pexp_t pe;
    tk = clk_16ms & ~prev16;
    prev16 = clk_16ms;
    #1;
    if (cq.size() > 0) begin
      ce = cq.pop_front();
      tests++;
      if (new_update !== ce) begin
        fails++;
        $display("FAIL new_update[%0d]: got %b expected %b", cidx, new_update, ce);
      end
      cidx++;
    end
    if (pq.size() > 0 && (!pq[0].at_tick || tk)) begin
      pe = pq.pop_front();
      tests++;
      if ({lcd_available, rs, data} !== {pe.avail, pe.rs, pe.data} || rw !== 1'b0) begin
        fails++;
        $display("FAIL lcd_write[%0d]: got avail=%b rs=%b rw=%b data=%h expected avail=%b rs=%b rw=0 data=%h",
                 pidx, lcd_available, rs, rw, data, pe.avail, pe.rs, pe.data);
      end
      pidx++;
    end
  end

  task automatic cd_step(input logic [3:0] f, input logic [2:0] h, input logic [2:0] j,
                         input logic [2:0] e, input logic ack, input logic exp);
    @(negedge clk);
    face = f; hunger = h; joy = j; energy = e; update_ack = ack;
    cq.push_back(exp);
  endtask

  // Queue the first nwrites of a full paint, request it, and wait for the monitor to drain.
  task automatic paint(input logic [3:0] n, input int rowset, input bit toggle, input int nwrites);
    pexp_t seq[$];
    logic [4:0] r;
    int k;
    seq.push_back({1'b1, 1'b0, 1'b0, 8'h40});
    for (int i = 0; i < 32; i++) begin
      r = (rowset == 4) ? face4_rows[i] : face0_rows[i];
      seq.push_back({1'b1, 1'b0, 1'b1, 3'b000, r});
    end
    for (int i = 0; i < 6; i++) seq.push_back({1'b1, 1'b0, place_rs[i], place_data[i]});
    seq.push_back({1'b1, 1'b1, 1'b0, 8'h00});
    @(negedge clk);
    num_cust_char = n;
    start_painting = 1'b1;
    for (int i = 0; i < nwrites; i++) pq.push_back(seq[i]);
    k = 0;
    while (pq.size() > 0 && k < 2000) begin
      @(negedge clk);
      k++;
      if (toggle) start_painting = (k < 1000) && ((k / 100) % 2 == 0);
      else if (!lcd_available) start_painting = 1'b0;
    end
    start_painting = 1'b0;
    if (pq.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL paint_timeout: %0d writes still pending, expected 0", pq.size());
      pq.delete();
    end
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    cq.push_back(1'b0);
    pq.push_back({1'b0, 1'b1, 1'b0, 8'h00});
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Change detector
    cd_step(4'd0, 3'd5, 3'd5, 3'd5, 1'b0, 1'b0);
    cd_step(4'd0, 3'd5, 3'd5, 3'd5, 1'b0, 1'b0);
    cd_step(4'd0, 3'd3, 3'd5, 3'd5, 1'b0, 1'b1);
    cd_step(4'd0, 3'd3, 3'd5, 3'd5, 1'b0, 1'b1);
    cd_step(4'd0, 3'd5, 3'd5, 3'd5, 1'b0, 1'b1);
    cd_step(4'd0, 3'd3, 3'd5, 3'd5, 1'b1, 1'b0);
    cd_step(4'd0, 3'd3, 3'd5, 3'd5, 1'b0, 1'b0);
    cd_step(4'd0, 3'd3, 3'd2, 3'd5, 1'b0, 1'b1);
    cd_step(4'd0, 3'd3, 3'd2, 3'd5, 1'b1, 1'b0);
    cd_step(4'd0, 3'd3, 3'd2, 3'd1, 1'b1, 1'b0);
    cd_step(4'd0, 3'd3, 3'd2, 3'd1, 1'b0, 1'b0);
    cd_step(4'd0, 3'd3, 3'd2, 3'd4, 1'b1, 1'b0);
    cd_step(4'd0, 3'd3, 3'd2, 3'd2, 1'b0, 1'b1);
    cd_step(4'd8, 3'd3, 3'd2, 3'd2, 1'b1, 1'b0);
    cd_step(4'd8, 3'd3, 3'd2, 3'd2, 1'b0, 1'b0);
    cd_step(4'd8, 3'd3, 3'd2, 3'd2, 1'b0, 1'b0);
    @(negedge clk);
    update_ack = 1'b0;
    @(negedge clk);

    // Painter
    slow_en = 1'b1;
    paint(4'd4, 4, 1'b0, 40);
    paint(4'd12, 0, 1'b1, 40);

    // Abort after ten writes, then restart
    paint(4'd0, 0, 1'b0, 10);
    @(negedge clk);
    reset = 1'b0;
    pq.push_back({1'b0, 1'b1, 1'b0, 8'h00});
    @(negedge clk);
    reset = 1'b1;
    paint(4'd4, 4, 1'b0, 3);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
